// File: rtl/vector_decoder_pkg.sv
// vector_decoder_pkg
//   Shared definitions for the vector decoder slice: the default vector
//   width N, the index width W (clog2 of N) and the two-state FSM encoding.
package vector_decoder_pkg;

  localparam int N = 32;
  localparam int W = 5;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/vector_decoder_idx_onehot.sv
// idx_onehot
//   Purely combinational decode of a W-bit bit-position index into an N-bit
//   one-hot vector. Indices that do not address a bit of the vector
//   (idx >= N, only possible when N < 2^W) yield an all-zero vector and
//   in_range = 0.
// Ports
//   idx       in   W  encoded bit position
//   onehot    out  N  one-hot decode of idx (zero when out of range)
//   in_range  out  1  idx < N
module idx_onehot
  import vector_decoder_pkg::*;
#(
  parameter int N = vector_decoder_pkg::N,
  parameter int W = vector_decoder_pkg::W
) (
  input  logic [W-1:0] idx,
  input  logic         unused_tie,
  output logic [N-1:0] onehot,
  output logic         in_range
);

  logic [N-1:0] one;

  always_comb begin
    one      = {{(N-1){1'b0}}, 1'b1};
    in_range = ({1'b0, idx} < (W+1)'(N));
    onehot   = in_range ? (one << idx) : '0;
  end

endmodule

// File: rtl/vector_decoder.sv
// vector_decoder
//   Rebuilds an N-bit vector from a stream of encoded bit-position beats.
//   Each accepted beat sets one bit of an accumulator; the beat flagged
//   in_last closes the frame, which is then held on the output until the
//   downstream consumer takes it. Duplicate or out-of-range indices are
//   dropped and flagged with a one-cycle err pulse.
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   en         in   1    input enable (does not affect the output side)
//   in_valid   in   1    index beat valid
//   in_ready   out  1    beat can be accepted
//   in_idx     in   W    encoded bit position
//   in_last    in   1    final beat of the frame
//   out_valid  out  1    completed frame available
//   out_ready  in   1    downstream accepts the frame
//   out_vec    out  N    rebuilt vector (live accumulator while collecting)
//   out_count  out  W+1  number of distinct bits set in out_vec
//   err        out  1    one-cycle pulse on duplicate/out-of-range index
module vector_decoder
  import vector_decoder_pkg::*;
#(
  parameter int N = vector_decoder_pkg::N,
  parameter int W = vector_decoder_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_idx,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_vec,
  output logic [W:0]   out_count,
  output logic         err
);

  state_t       state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [W:0]   count_q, count_d;
  logic         err_q, err_d;

  logic [N-1:0] idx_hot;
  logic         idx_in_range;
  logic         accept;

  idx_onehot #(
    .N (N),
    .W (W)
  ) u_idx_onehot (
    .idx        (in_idx),
    .unused_tie (1'b0),
    .onehot     (idx_hot),
    .in_range   (idx_in_range)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // A beat whose bit is already set (or cannot exist) leaves the frame
  // untouched but still closes it when in_last is set.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (!idx_in_range || ((acc_q & idx_hot) != '0)) begin
            err_d = 1'b1;
          end else begin
            acc_d   = acc_q | idx_hot;
            count_d = count_q + {{W{1'b0}}, 1'b1};
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // in_ready is low throughout HOLD, so no beat can slip in during the
  // cycle the output handshake completes.
  always_comb begin
    in_ready  = en && (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    out_vec   = acc_q;
    out_count = count_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_vector_decoder.sv
// tb_vector_decoder
//   Directed self-checking bench for vector_decoder. Inputs change 1 time
//   unit after each rising edge; outputs are sampled at the same point.
module tb_vector_decoder;

  localparam int N = 32;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_idx;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_vec;
  logic [W:0]   out_count;
  logic         err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vector_decoder #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_count (out_count),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] idx, input logic last);
    in_valid = v;
    in_idx   = idx;
    in_last  = last;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_vec",   64'(out_vec),   64'd0);
    checkOutput("rst_out_count", 64'(out_count), 64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("rst_err",       64'(err),       64'd0);

    // Frame 0,1,4 with out_ready held high
    out_ready = 1'b1;
    applyStimulus(1'b1, 5'd0, 1'b0);
    checkOutput("f1_partial_valid", 64'(out_valid), 64'd0);
    checkOutput("f1_partial_count", 64'(out_count), 64'd1);
    applyStimulus(1'b1, 5'd1, 1'b0);
    checkOutput("f1_partial_vec",   64'(out_vec),   64'h3);
    applyStimulus(1'b1, 5'd4, 1'b1);
    checkOutput("f1_out_valid", 64'(out_valid), 64'd1);
    checkOutput("f1_out_vec",   64'(out_vec),   64'h13);
    checkOutput("f1_out_count", 64'(out_count), 64'd3);
    checkOutput("f1_in_ready",  64'(in_ready),  64'd0);
    checkOutput("f1_err",       64'(err),       64'd0);
    // Offer a beat during the handshake cycle; it must not be taken
    applyStimulus(1'b1, 5'd9, 1'b0);
    checkOutput("f1_after_valid", 64'(out_valid), 64'd0);
    checkOutput("f1_after_vec",   64'(out_vec),   64'd0);
    checkOutput("f1_after_count", 64'(out_count), 64'd0);
    checkOutput("f1_after_ready", 64'(in_ready),  64'd1);
    in_valid = 1'b0;

    // Duplicate index 31
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd31, 1'b0);
    checkOutput("dup_err_first", 64'(err), 64'd0);
    applyStimulus(1'b1, 5'd31, 1'b1);
    checkOutput("dup_err_pulse", 64'(err),       64'd1);
    checkOutput("dup_valid",     64'(out_valid), 64'd1);
    checkOutput("dup_vec",       64'(out_vec),   64'h80000000);
    checkOutput("dup_count",     64'(out_count), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("dup_err_clear", 64'(err),       64'd0);
    checkOutput("dup_done",      64'(out_valid), 64'd0);

    // Backpressure: frame 10, 20 held for 5 cycles
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd10, 1'b0);
    applyStimulus(1'b1, 5'd20, 1'b1);
    in_valid = 1'b1;
    in_idx   = 5'd3;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid",    64'(out_valid), 64'd1);
      checkOutput("bp_vec",      64'(out_vec),   64'h00100400);
      checkOutput("bp_count",    64'(out_count), 64'd2);
      checkOutput("bp_in_ready", 64'(in_ready),  64'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_done_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_done_count", 64'(out_count), 64'd0);

    // Enable gating
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd2, 1'b0);
    en = 1'b0;
    in_idx = 5'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("en_in_ready", 64'(in_ready),  64'd0);
      checkOutput("en_vec",      64'(out_vec),   64'h4);
      checkOutput("en_count",    64'(out_count), 64'd1);
    end
    en = 1'b1;
    applyStimulus(1'b1, 5'd3, 1'b1);
    checkOutput("en_out_valid", 64'(out_valid), 64'd1);
    checkOutput("en_out_vec",   64'(out_vec),   64'hC);
    checkOutput("en_out_count", 64'(out_count), 64'd2);
    // Output handshake with en low still completes
    in_valid  = 1'b0;
    en        = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("en_hs_valid", 64'(out_valid), 64'd0);
    en = 1'b1;

    // Reset mid-frame
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd5, 1'b0);
    applyStimulus(1'b1, 5'd6, 1'b0);
    checkOutput("mid_partial_vec", 64'(out_vec), 64'h60);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_vec",   64'(out_vec),   64'd0);
    checkOutput("mid_rst_count", 64'(out_count), 64'd0);
    applyStimulus(1'b1, 5'd7, 1'b1);
    checkOutput("mid_valid", 64'(out_valid), 64'd1);
    checkOutput("mid_vec",   64'(out_vec),   64'h80);
    checkOutput("mid_count", 64'(out_count), 64'd1);

    // Reset discards a held frame
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("hold_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("hold_rst_vec",   64'(out_vec),   64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
